// File: rtl/max_pooling_stream_pkg.sv
// Shared constants and helpers for the 2x2 stride-2 max-pooling stream.
// Argmax encoding is used only when MAXPOOL_ARGMAX_EN is defined.
package maxpool_pkg;

  localparam logic [1:0] IDX_TL = 2'b00;
  localparam logic [1:0] IDX_TR = 2'b01;
  localparam logic [1:0] IDX_BL = 2'b10;
  localparam logic [1:0] IDX_BR = 2'b11;

  // Pooled output extent along one axis (floor semantics)
  function automatic int unsigned pooled_dim(input int unsigned n);
    return n / 2;
  endfunction

endpackage

// File: rtl/max_pooling_stream_if.sv
// Valid/ready input and output streams of max_pooling_stream.
// out_idx exists only when MAXPOOL_ARGMAX_EN is defined.
interface max_pooling_stream_if #(
  parameter int unsigned DATA_BITS = 32,
  parameter int unsigned CH        = 1
);

  logic                    in_valid;
  logic                    in_ready;
  logic [CH*DATA_BITS-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [CH*DATA_BITS-1:0] out_data;
  logic                    out_last;
`ifdef MAXPOOL_ARGMAX_EN
  logic [CH*2-1:0]         out_idx;
`endif

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
`ifdef MAXPOOL_ARGMAX_EN
    , output out_idx
`endif
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
`ifdef MAXPOOL_ARGMAX_EN
    , input out_idx
`endif
  );

endinterface

// File: rtl/max_pooling_stream_max2_sel.sv
// Signed strict two-input max; sel_o is 1 only when b_i is strictly larger,
// so ties resolve to a_i (the earlier pixel).
module max2_sel #(
  parameter int unsigned DATA_BITS = 32
) (
  input  logic [DATA_BITS-1:0] a_i,
  input  logic [DATA_BITS-1:0] b_i,
  output logic [DATA_BITS-1:0] max_o,
  output logic                 sel_o
);

  assign sel_o = $signed(b_i) > $signed(a_i);
  assign max_o = sel_o ? b_i : a_i;

endmodule

// File: rtl/max_pooling_stream.sv
// Streaming 2x2 stride-2 max pooling with a half-row line buffer.
// Optional argmax output enabled by MAXPOOL_ARGMAX_EN.
module max_pooling_stream
  import maxpool_pkg::*;
#(
  parameter int unsigned DATA_BITS = 32,
  parameter int unsigned W         = 46,
  parameter int unsigned H         = 46,
  parameter int unsigned CH        = 1
) (
  input logic                clk,
  input logic                reset,
  max_pooling_stream_if.slave strm
);

  localparam int unsigned HW    = pooled_dim(W);
  localparam int unsigned HH    = pooled_dim(H);
  localparam int unsigned CW    = $clog2(W);
  localparam int unsigned RW    = $clog2(H);
  localparam int unsigned IW    = (HW > 1) ? $clog2(HW) : 1;
  localparam bit          ODD_W = (W % 2) == 1;
  localparam bit          ODD_H = (H % 2) == 1;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  logic [DATA_BITS-1:0] h_q [CH];
  logic [DATA_BITS-1:0] h_d [CH];

  logic [CH*DATA_BITS-1:0] lbuf_q [HW];
  logic [CH*DATA_BITS-1:0] lb_rd;
  logic [CH*DATA_BITS-1:0] hpack;
  logic [CH*DATA_BITS-1:0] pooled;

  logic [DATA_BITS-1:0] hmax [CH];
  logic [DATA_BITS-1:0] vmax [CH];
  logic [CH-1:0]        hsel;
  logic [CH-1:0]        vsel;

  logic                    out_valid_q, out_valid_d;
  logic [CH*DATA_BITS-1:0] out_data_q, out_data_d;
  logic                    out_last_q, out_last_d;

  logic          accept, col_last, row_last, col_keep, row_keep;
  logic          store_h, pair, wr_lbuf, emit, final_win;
  logic [IW-1:0] lidx;

  assign strm.in_ready = !out_valid_q || strm.out_ready;
  assign accept        = strm.in_valid && strm.in_ready;

  assign col_last  = col_q == CW'(W - 1);
  assign row_last  = row_q == RW'(H - 1);
  // Trailing odd column/row beats are consumed without touching any state
  assign col_keep  = !(ODD_W && col_last);
  assign row_keep  = !(ODD_H && row_last);
  assign store_h   = accept && !col_q[0] && col_keep;
  assign pair      = accept && col_q[0];
  assign wr_lbuf   = pair && !row_q[0] && row_keep;
  assign emit      = pair && row_q[0];
  assign final_win = (row_q == RW'(2 * HH - 1)) && (col_q == CW'(2 * HW - 1));
  assign lidx      = IW'(col_q >> 1);
  assign lb_rd     = lbuf_q[lidx];

  for (genvar k = 0; k < CH; k++) begin : g_ch
    max2_sel #(.DATA_BITS(DATA_BITS)) u_hcmp (
      .a_i   (h_q[k]),
      .b_i   (strm.in_data[k*DATA_BITS +: DATA_BITS]),
      .max_o (hmax[k]),
      .sel_o (hsel[k])
    );
    max2_sel #(.DATA_BITS(DATA_BITS)) u_vcmp (
      .a_i   (lb_rd[k*DATA_BITS +: DATA_BITS]),
      .b_i   (hmax[k]),
      .max_o (vmax[k]),
      .sel_o (vsel[k])
    );
    assign hpack[k*DATA_BITS +: DATA_BITS]  = hmax[k];
    assign pooled[k*DATA_BITS +: DATA_BITS] = vmax[k];
  end

`ifdef MAXPOOL_ARGMAX_EN
  logic [CH-1:0]   lsel_q [HW];
  logic [CH-1:0]   lsel_rd;
  logic [CH*2-1:0] idx_w;
  logic [CH*2-1:0] out_idx_q, out_idx_d;

  assign lsel_rd = lsel_q[lidx];

  for (genvar k = 0; k < CH; k++) begin : g_idx
    assign idx_w[k*2 +: 2] = vsel[k] ? (hsel[k]    ? IDX_BR : IDX_BL)
                                     : (lsel_rd[k] ? IDX_TR : IDX_TL);
  end

  always_ff @(posedge clk) begin
    if (wr_lbuf) lsel_q[lidx] <= hsel;
  end

  always_ff @(posedge clk) begin
    if (reset) out_idx_q <= '0;
    else       out_idx_q <= out_idx_d;
  end

  always_comb begin
    out_idx_d = out_idx_q;
    if (emit) out_idx_d = idx_w;
  end

  assign strm.out_idx = out_idx_q;
`else
  logic unused_sel;
  assign unused_sel = ^{hsel, vsel};
`endif

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < CH; k++) begin
      h_d[k] = store_h ? strm.in_data[k*DATA_BITS +: DATA_BITS] : h_q[k];
    end
  end

  // A drain and a new load in the same cycle resolve to the new load
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (out_valid_q && strm.out_ready) out_valid_d = 1'b0;
    if (emit) begin
      out_valid_d = 1'b1;
      out_data_d  = pooled;
      out_last_d  = final_win;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < CH; k++) h_q[k] <= h_d[k];
  end

  always_ff @(posedge clk) begin
    if (wr_lbuf) lbuf_q[lidx] <= hpack;
  end

  assign strm.out_valid = out_valid_q;
  assign strm.out_data  = out_data_q;
  assign strm.out_last  = out_last_q;

endmodule

// File: doc/max_pooling_stream.md
Name: max_pooling_stream

Overview:
- Streaming 2x2 stride-2 max-pooling engine.
- Consumes one raster-order pixel (CH channels in parallel) per accepted beat. Emits one pooled pixel per 2x2 window.
- Holds a half-row line buffer instead of the whole feature map.
- Sits between a conv/activation stage and the next layer, with valid/ready on both sides.

Parameters:
- DATA_BITS, 32, width of one channel element; signed two's complement.
- W, 46, input feature-map width in pixels; >= 2.
- H, 46, input feature-map height in pixels; >= 2.
- CH, 1, channels carried per beat; each channel is pooled independently.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  input beat valid
- in_ready  output  1  block accepts a beat this cycle
- in_data  input  CH*DATA_BITS  pixel; channel k at [k*DATA_BITS +: DATA_BITS]
- out_valid  output  1  pooled pixel valid
- out_ready  input  1  downstream accepts
- out_data  output  CH*DATA_BITS  pooled pixel, same channel packing
- out_last  output  1  high with the final pooled pixel of a frame
- out_idx  output  CH*2  per-channel argmax; present only with MAXPOOL_ARGMAX_EN

Behaviour:
- Clock and reset: single clock; synchronous active-high reset.
- Reset values: in_ready=1, out_valid=0, out_data=0, out_last=0, out_idx=0. Column and row counters=0, line buffer contents don't-care.
- Reset mid-frame abandons the partial frame; the next accepted beat is pixel (0,0).
- Handshake:
  - A beat is accepted when in_valid && in_ready.
  - in_ready = !out_valid || out_ready, so a full output register stalls input (no skid beyond one register).
  - out_data, out_last and out_idx are held stable while out_valid && !out_ready.
- Counters: col runs 0..W-1, row runs 0..H-1, both advancing on acceptance. col wraps to 0 and increments row; row wraps to 0 after (W-1,H-1).
- Per accepted beat at (row, col), per channel:
  - Even col: store value in h_reg.
  - Odd col: p = max(h_reg, in).
    - Even row: write p to lbuf[col/2].
    - Odd row: result = max(lbuf[col/2], p), loaded into the output register.
- Output: the output register sets out_valid=1 on the clock edge that accepts the window's bottom-right pixel, so latency is 1 cycle.
- out_last is set when the window is the final one: row = 2*floor(H/2)-1 and col = 2*floor(W/2)-1.
- Comparison is signed and strict (a > b). On ties the earlier pixel wins, in order TL, TR, BL, BR.
- Odd dimensions (floor semantics):
  - Odd W: last column beats are accepted and discarded, and do not touch h_reg or lbuf.
  - Odd H: the last row is accepted and discarded, with out_valid never set.
  - Output map is floor(W/2) x floor(H/2).
- Simultaneous events: a beat accepted while out_valid && out_ready in the same cycle replaces the output register cleanly.
- Line buffer: floor(W/2) x CH*DATA_BITS registers or RAM. Read and write indices both equal col/2.

Optional Feature:
- Macro: MAXPOOL_ARGMAX_EN.
- Defined:
  - out_idx port exists; per channel 2'b00=TL, 01=TR, 10=BL, 11=BR, same tie rule.
  - The line buffer carries one extra bit per channel (horizontal winner).
  - out_idx is registered alongside out_data.
- Undefined: no out_idx port, no extra storage; out_data is identical.

Decomposition:
- Package maxpool_pkg holds the argmax encoding constants (IDX_TL, IDX_TR, IDX_BL, IDX_BR) and a function returning the pooled output dimension floor(n/2).
- One sub-module, max2_sel: combinational signed strict compare of two DATA_BITS values.
  - Outputs max and sel (1 when b wins).
  - Instantiated CH times for the horizontal stage and CH times for the vertical stage.

Test Plan:
- W=4,H=4,CH=1, rows [1 2 3 4],[5 6 7 8],[9 10 11 12],[13 14 15 16], out_ready=1 -> outputs 6,8,14,16. out_last only on 16. Each output one cycle after its BR pixel.
- Negatives: window -5,-3,-9,-7 -> output -3 (idx 01 with ARGMAX). Window all 7 -> output 7, idx 00.
- Backpressure: hold out_ready=0 after first output -> in_ready drops. out_data=6 held stable. Releasing it resumes the stream with no lost or duplicated pixels.
- W=5,H=5 with pixel value = row*5+col -> 4 outputs: 6,8,16,18. Column 4 and row 4 are dropped; out_last on 18.
- Assert reset after 6 beats of a frame, then send a full 4x4 frame -> outputs match the clean first scenario.
- CH=2, channel0 = scenario 1 data, channel1 = its negation -> channel1 outputs -1,-3,-9,-11 alongside channel0.
